// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns unit: one 32-bit column mixed one output byte
// per cycle through a single shared GF(2^8) byte datapath, valid/ready with flush.
module xc_aesmix (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned COL_W  = 32;
    localparam int unsigned NREG   = 3;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NREG-1:0]   r_we;
    logic [BYTE_W-1:0] r0;
    logic [BYTE_W-1:0] r1;
    logic [BYTE_W-1:0] r2;

    logic [COL_W-1:0]  column;
    logic [COL_W-1:0]  rot;
    logic [BYTE_W-1:0] x0, x1, x2, x3;
    logic [BYTE_W-1:0] x0_2, x0_4, x0_8;
    logic [BYTE_W-1:0] x1_2, x1_4, x1_8;
    logic [BYTE_W-1:0] x2_2, x2_4, x2_8;
    logic [BYTE_W-1:0] x3_2, x3_4, x3_8;
    logic [BYTE_W-1:0] mix_enc;
    logic [BYTE_W-1:0] mix_dec;
    logic [BYTE_W-1:0] dp_out;

    // Upper rs1 and lower rs2 halves carry no column bytes.
    logic unused_fields;
    assign unused_fields = ^{rs1[31:16], rs2[15:0]};

    // Multiply by 02 in GF(2^8) modulo 0x11B.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Operands are gated with valid so the datapath stays quiet while stalled.
    assign column = {rs2[31:16], rs1[15:0]} & {COL_W{valid}};

    // Rotate right by one byte per state so a[fsm] lands in the low lane.
    always_comb begin
        rot = column;
        case (state)
            S0: rot = column;
            S1: rot = {column[7:0],  column[31:8]};
            S2: rot = {column[15:0], column[31:16]};
            S3: rot = {column[23:0], column[31:24]};
        endcase
    end

    assign x0 = rot[7:0];
    assign x1 = rot[15:8];
    assign x2 = rot[23:16];
    assign x3 = rot[31:24];

    // Chained doublings shared by both directions.
    assign x0_2 = xtime(x0);
    assign x0_4 = xtime(x0_2);
    assign x0_8 = xtime(x0_4);
    assign x1_2 = xtime(x1);
    assign x1_4 = xtime(x1_2);
    assign x1_8 = xtime(x1_4);
    assign x2_2 = xtime(x2);
    assign x2_4 = xtime(x2_2);
    assign x2_8 = xtime(x2_4);
    assign x3_2 = xtime(x3);
    assign x3_4 = xtime(x3_2);
    assign x3_8 = xtime(x3_4);

    // 02*a ^ 03*b ^ c ^ d
    assign mix_enc = x0_2 ^ (x1_2 ^ x1) ^ x2 ^ x3;

    // 0E*a ^ 0B*b ^ 0D*c ^ 09*d
    assign mix_dec = (x0_8 ^ x0_4 ^ x0_2)
                   ^ (x1_8 ^ x1_2 ^ x1)
                   ^ (x2_8 ^ x2_4 ^ x2)
                   ^ (x3_8 ^ x3);

    assign dp_out = enc ? mix_enc : mix_dec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, byte-register enables and the completion handshake.
    always_comb begin
        state_nxt = state;
        r_we      = '0;
        ready     = 1'b0;
        if (flush) begin
            state_nxt = S0;
        end else if (valid) begin
            case (state)
                S0: begin
                    r_we[0]   = 1'b1;
                    state_nxt = S1;
                end
                S1: begin
                    r_we[1]   = 1'b1;
                    state_nxt = S2;
                end
                S2: begin
                    r_we[2]   = 1'b1;
                    state_nxt = S3;
                end
                S3: begin
                    ready     = 1'b1;
                    state_nxt = S0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            if (r_we[0]) r0 <= dp_out;
            if (r_we[1]) r1 <= dp_out;
            if (r_we[2]) r2 <= dp_out;
        end
    end

    assign result = ready ? {dp_out, r2, r1, r0} : COL_W'(0);

endmodule

// File: tb/tb_xc_aesmix.sv
// Bench for xc_aesmix: directed vectors plus random columns against a
// GF(2^8) matrix-product reference model.
module tb_xc_aesmix;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    xc_aesmix dut (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .valid  (valid),
        .rs1    (rs1),
        .rs2    (rs2),
        .enc    (enc),
        .ready  (ready),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    // Circulant matrix product over the column a0..a3 (a0 = low byte).
    function automatic logic [31:0] mix_model(input logic [31:0] col, input logic e);
        logic [7:0] a [4];
        logic [7:0] c [4];
        logic [7:0] b;
        logic [31:0] r;
        if (e) begin
            c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
        end else begin
            c[0] = 8'h0E; c[1] = 8'h0B; c[2] = 8'h0D; c[3] = 8'h09;
        end
        for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(c[j], a[(i + j) % 4]);
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic v, input logic f, input logic [31:0] a, input logic [31:0] b,
                         input logic e);
        @(negedge clock);
        valid = v;
        flush = f;
        rs1   = a;
        rs2   = b;
        enc   = e;
        #1;
    endtask

    // Full operation with optional stall of stall_len cycles before step stall_at.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic [31:0] exp,
                          input int stall_at, input int stall_len);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    drive(1'b0, 1'b0, a, b, e);
                    check({tag, " stall ready"}, 32'(ready), 32'd0);
                    check({tag, " stall result"}, result, 32'd0);
                end
            end
            drive(1'b1, 1'b0, a, b, e);
            if (k < 3) begin
                check({tag, " early ready"}, 32'(ready), 32'd0);
            end else begin
                check({tag, " ready"}, 32'(ready), 32'd1);
                check({tag, " result"}, result, exp);
            end
        end
    endtask

    initial begin
        logic [31:0] col;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        re;
        int          sat;
        int          slen;

        reset = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        rs1   = 32'h0;
        rs2   = 32'h0;
        enc   = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset ready", 32'(ready), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("idle ready", 32'(ready), 32'd0);
        check("idle result", result, 32'd0);

        // Reference vectors.
        run_op("ref_enc", 32'h000013DB, 32'h45530000, 1'b1, 32'hBCA14D8E, -1, 0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("after ready", 32'(ready), 32'd0);
        run_op("ref_dec", 32'h00004D8E, 32'hBCA10000, 1'b0, 32'h455313DB, -1, 0);
        run_op("f20a", 32'h00000AF2, 32'h5C220000, 1'b1, 32'h9D58DC9F, -1, 0);

        // Back-to-back fixed points.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        run_op("b2b_c6", 32'h0000C6C6, 32'hC6C60000, 1'b1, 32'hC6C6C6C6, -1, 0);
        run_op("b2b_01", 32'h00000101, 32'h01010000, 1'b1, 32'h01010101, -1, 0);

        // Stall in S2 for two cycles.
        run_op("stall", 32'h0000D4D4, 32'hD5D40000, 1'b1, 32'hD6D7D5D5, 2, 2);

        // Flush in S2, then a clean op.
        drive(1'b1, 1'b0, 32'h000013DB, 32'h45530000, 1'b1);
        drive(1'b1, 1'b0, 32'h000013DB, 32'h45530000, 1'b1);
        drive(1'b1, 1'b1, 32'h000013DB, 32'h45530000, 1'b1);
        check("flush s2 ready", 32'(ready), 32'd0);
        run_op("post_flush", 32'h000013DB, 32'h45530000, 1'b1, 32'hBCA14D8E, -1, 0);

        // Flush in S3 suppresses ready.
        drive(1'b1, 1'b0, 32'h00000AF2, 32'h5C220000, 1'b1);
        drive(1'b1, 1'b0, 32'h00000AF2, 32'h5C220000, 1'b1);
        drive(1'b1, 1'b0, 32'h00000AF2, 32'h5C220000, 1'b1);
        drive(1'b1, 1'b1, 32'h00000AF2, 32'h5C220000, 1'b1);
        check("flush s3 ready", 32'(ready), 32'd0);
        run_op("post_flush3", 32'h00000AF2, 32'h5C220000, 1'b1, 32'h9D58DC9F, -1, 0);

        // Reset mid-operation.
        drive(1'b1, 1'b0, 32'h00004D8E, 32'hBCA10000, 1'b0);
        drive(1'b1, 1'b0, 32'h00004D8E, 32'hBCA10000, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid reset ready", 32'(ready), 32'd0);
        check("mid reset result", result, 32'd0);
        run_op("post_reset", 32'h00004D8E, 32'hBCA10000, 1'b0, 32'h455313DB, -1, 0);

        // Ignored operand fields.
        run_op("ignored", 32'hFFFF13DB, 32'h4553FFFF, 1'b1, 32'hBCA14D8E, -1, 0);

        // Random columns, directions, junk fields and stalls.
        for (int t = 0; t < 40; t++) begin
            ra   = $urandom;
            rb   = $urandom;
            re   = 1'($urandom_range(0, 1));
            sat  = $urandom_range(0, 4);
            slen = $urandom_range(0, 3);
            col  = {rb[31:16], ra[15:0]};
            run_op("rand", ra, rb, re, mix_model(col, re), sat, slen);
            if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, ra, rb, re);
        end

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
